// File: rtl/pipeif_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
// Combinational only: no latency, no backpressure.
package pipeif_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT_ID = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    // All-zero word decodes as no register write, no memory access.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipeif_npc.sv
// Next-PC selector: picks sequential, branch, register or jump target, word aligned.
// Purely combinational, zero latency, no backpressure.
module pipeif_npc
    import pipeif_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    output logic [31:0] target
);

    always_comb begin
        target = word_align(pc4);
        unique case (pcsource)
            PCSRC_SEQ: target = word_align(pc4);
            PCSRC_BR:  target = word_align(bpc);
            PCSRC_JR:  target = word_align(ra);
            PCSRC_J:   target = word_align(jpc);
        endcase
    end

endmodule

// File: rtl/pipeif.sv
// Fetch stage + IF/ID register; fetched word reaches inst one cycle after the transfer.
// Decode stalls land in a one-entry skid buffer (request dropped while full); PIPEIF_PERF_EN adds perf counters.
module pipeif
    import pipeif_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        load_depen,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, tgt, tgt_nxt;
    logic [31:0] dinst, dinst_nxt, dpc4_nxt;
    logic        dvalid_nxt;
    logic [31:0] binst, binst_nxt, bpc4, bpc4_nxt;
    logic [31:0] pc4, target;
    logic        advance, redirect, slot_free, xfer;

    assign pc4       = pc + 32'd4;
    assign advance   = dvalid & ~load_depen;
    assign redirect  = advance & (pcsource != PCSRC_SEQ);
    assign slot_free = ~dvalid | advance;
    assign imem_req  = clrn & (state != WAIT_ID);
    assign imem_addr = pc;
    assign xfer      = imem_req & imem_ready;
    assign inst      = dvalid ? dinst : NOP_INST;

    pipeif_npc u_npc (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .ra       (ra),
        .jpc      (jpc),
        .target   (target)
    );

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        tgt_nxt    = tgt;
        dinst_nxt  = dinst;
        dpc4_nxt   = dpc4;
        dvalid_nxt = dvalid;
        binst_nxt  = binst;
        bpc4_nxt   = bpc4;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    dvalid_nxt = 1'b0;
                    // The in-flight fetch is wrong-path; if it cannot finish now, park the target.
                    if (xfer) begin
                        pc_nxt = target;
                    end else begin
                        tgt_nxt   = target;
                        state_nxt = DROP;
                    end
                end else if (xfer) begin
                    pc_nxt = pc4;
                    if (slot_free) begin
                        dinst_nxt  = imem_rdata;
                        dpc4_nxt   = pc4;
                        dvalid_nxt = 1'b1;
                    end else begin
                        binst_nxt = imem_rdata;
                        bpc4_nxt  = pc4;
                        state_nxt = WAIT_ID;
                    end
                end else if (advance) begin
                    dvalid_nxt = 1'b0;
                end
            end
            WAIT_ID: begin
                if (redirect) begin
                    pc_nxt     = target;
                    dvalid_nxt = 1'b0;
                    state_nxt  = FETCH;
                end else if (advance) begin
                    dinst_nxt  = binst;
                    dpc4_nxt   = bpc4;
                    dvalid_nxt = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            DROP: begin
                if (xfer) begin
                    pc_nxt    = tgt;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            tgt    <= '0;
            dinst  <= '0;
            dpc4   <= '0;
            dvalid <= 1'b0;
            binst  <= '0;
            bpc4   <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            tgt    <= tgt_nxt;
            dinst  <= dinst_nxt;
            dpc4   <= dpc4_nxt;
            dvalid <= dvalid_nxt;
            binst  <= binst_nxt;
            bpc4   <= bpc4_nxt;
        end
    end

`ifdef PIPEIF_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (dvalid & load_depen) stall_cnt <= stall_cnt + 32'd1;
            if (redirect)            flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_stall = stall_cnt;
    assign perf_flush = flush_cnt;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
